// File: rtl/div_pkg.sv
// Shared defaults and width helper for the divider result buffer.
package div_pkg;

    localparam int unsigned DefDividendBitdepth = 16;
    localparam int unsigned DefDepth            = 8;

    // Smallest n with 2**n >= value; used for pointer and count widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/div_result_buf_fifo.sv
// Show-ahead FIFO with wrap-bit pointers and a sticky overflow flag.
// The head reads as zero whenever the FIFO is empty.
module div_result_buf_fifo
    import div_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = DefDepth,
    localparam int unsigned PtrW = clog2(Depth) + 1,
    localparam int unsigned AddrW = PtrW - 1
) (
    input  logic             i_sclk,
    input  logic             i_rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic [PtrW-1:0]  count_o,
    output logic             overflow_o
);

    localparam logic [PtrW-1:0] FullXor = {1'b1, {AddrW{1'b0}}};

    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic [Width-1:0] mem_q [Depth];

    logic empty, full, push_en, pop_en;

    assign empty   = (wptr_q == rptr_q);
    assign full    = ((wptr_q ^ rptr_q) == FullXor);
    assign pop_en  = pop_i & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_en = push_i & (~full | pop_en);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        if (push_en) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop_en) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (push_i && full && !pop_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_sclk) begin
        if (push_en) begin
            mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o    = empty ? '0 : mem_q[rptr_q[AddrW-1:0]];
    assign empty_o    = empty;
    assign count_o    = wptr_q - rptr_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/div_result_buf.sv
// Credit-managed result buffer behind a divider with no backpressure.
// Define DIV_RESULT_BUF_BYPASS_EN to pass results straight through when empty.
module div_result_buf
    import div_pkg::*;
#(
    parameter int unsigned DIVIDEND_BITDEPTH = DefDividendBitdepth,
    parameter int unsigned DEPTH = DefDepth,
    localparam int unsigned CntW = clog2(DEPTH) + 1
) (
    input  logic                         i_sclk,
    input  logic                         i_rstn,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic                         i_div_valid,
    input  logic [DIVIDEND_BITDEPTH-1:0] i_div_quotient,
    input  logic [DIVIDEND_BITDEPTH-1:0] i_div_remainder,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DIVIDEND_BITDEPTH-1:0] o_quotient,
    output logic [DIVIDEND_BITDEPTH-1:0] o_remainder,
    output logic [CntW-1:0]              o_count,
    output logic                         o_overflow
);

    localparam int unsigned Width = 2 * DIVIDEND_BITDEPTH;

    logic [CntW-1:0]  inflight_q, inflight_d;
    logic [CntW:0]    credits_used;
    logic [Width-1:0] head;
    logic             fifo_empty;
    logic             issue, push, pop, bypass;

    // Credits count queued plus in-flight results, so space is reserved at issue time.
    assign credits_used = (CntW + 1)'(o_count) + (CntW + 1)'(inflight_q);
    assign o_req_ready  = (credits_used < (CntW + 1)'(DEPTH));
    assign issue        = i_req_valid & o_req_ready;

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !i_div_valid) begin
            inflight_d = inflight_q + CntW'(1);
        end else if (!issue && i_div_valid && (inflight_q != '0)) begin
            inflight_d = inflight_q - CntW'(1);
        end
    end

    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

`ifdef DIV_RESULT_BUF_BYPASS_EN
    assign bypass = fifo_empty & i_div_valid & i_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push    = i_div_valid & ~bypass;
    assign pop     = ~fifo_empty & i_ready;
    assign o_valid = ~fifo_empty | bypass;

    always_comb begin
        o_quotient  = head[Width-1:DIVIDEND_BITDEPTH];
        o_remainder = head[DIVIDEND_BITDEPTH-1:0];
        if (bypass) begin
            o_quotient  = i_div_quotient;
            o_remainder = i_div_remainder;
        end
    end

    div_result_buf_fifo #(
        .Width (Width),
        .Depth (DEPTH)
    ) u_fifo (
        .i_sclk     (i_sclk),
        .i_rstn     (i_rstn),
        .push_i     (push),
        .pop_i      (pop),
        .wdata_i    ({i_div_quotient, i_div_remainder}),
        .rdata_o    (head),
        .empty_o    (fifo_empty),
        .count_o    (o_count),
        .overflow_o (o_overflow)
    );

endmodule

// File: tb/tb_div_result_buf.sv
// Bench for div_result_buf (DEPTH=4): queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_div_result_buf;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CntW  = 3;

    logic            i_sclk = 1'b0;
    logic            i_rstn = 1'b0;
    logic            i_req_valid = 1'b0;
    logic            i_div_valid = 1'b0;
    logic            i_ready = 1'b0;
    logic [W-1:0]    i_div_quotient = '0;
    logic [W-1:0]    i_div_remainder = '0;
    logic            o_req_ready, o_valid, o_overflow;
    logic [W-1:0]    o_quotient, o_remainder;
    logic [CntW-1:0] o_count;

    div_result_buf #(
        .DIVIDEND_BITDEPTH (W),
        .DEPTH             (DEPTH)
    ) dut (
        .i_sclk          (i_sclk),
        .i_rstn          (i_rstn),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_div_valid     (i_div_valid),
        .i_div_quotient  (i_div_quotient),
        .i_div_remainder (i_div_remainder),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_quotient      (o_quotient),
        .o_remainder     (o_remainder),
        .o_count         (o_count),
        .o_overflow      (o_overflow)
    );

    always #5 i_sclk = ~i_sclk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {quotient, remainder}, an in-flight count and a sticky flag.
    logic [31:0] mq[$];
    int          m_inflight = 0;
    bit          m_ovf = 1'b0;
    int          m_sz;
    bit          m_issue, m_pop, m_byp;

    function automatic bit bypass_now();
`ifdef DIV_RESULT_BUF_BYPASS_EN
        return (mq.size() == 0) && i_div_valid && i_ready;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge i_sclk or negedge i_rstn);
            if (!i_rstn) begin
                mq.delete();
                m_inflight = 0;
                m_ovf = 1'b0;
            end else begin
                m_sz    = mq.size();
                m_issue = i_req_valid && ((m_sz + m_inflight) < DEPTH);
                m_byp   = bypass_now();
                m_pop   = (m_sz > 0) && i_ready;
                if (m_pop) void'(mq.pop_front());
                if (i_div_valid && !m_byp) begin
                    if (m_sz == DEPTH && !m_pop) m_ovf = 1'b1;
                    else mq.push_back({i_div_quotient, i_div_remainder});
                end
                if (m_issue && !i_div_valid) m_inflight++;
                else if (!m_issue && i_div_valid && m_inflight > 0) m_inflight--;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    int        pops_seen = 0;
    int        max_model_inflight = 0;
    bit        e_valid, e_byp;
    logic [15:0] e_q, e_r;

    initial begin
        forever begin
            @(negedge i_sclk);
            e_byp   = bypass_now();
            e_valid = (mq.size() > 0) || e_byp;
            e_q     = (mq.size() > 0) ? mq[0][31:16] : (e_byp ? i_div_quotient : 16'd0);
            e_r     = (mq.size() > 0) ? mq[0][15:0] : (e_byp ? i_div_remainder : 16'd0);
            check("cyc_valid", 32'(o_valid), 32'(e_valid));
            check("cyc_quotient", 32'(o_quotient), 32'(e_q));
            check("cyc_remainder", 32'(o_remainder), 32'(e_r));
            check("cyc_count", 32'(o_count), 32'(mq.size()));
            check("cyc_req_ready", 32'(o_req_ready), 32'((mq.size() + m_inflight) < DEPTH));
            check("cyc_overflow", 32'(o_overflow), 32'(m_ovf));
            if (m_inflight > max_model_inflight) max_model_inflight = m_inflight;
            if (i_rstn && o_valid && i_ready) pops_seen++;
        end
    end

    task automatic tick();
        @(posedge i_sclk);
        #1;
    endtask

    logic [15:0] fill_q [4] = '{16'd14, 16'd3, 16'd0, 16'd65535};
    logic [15:0] fill_r [4] = '{16'd2, 16'd1, 16'd9, 16'd0};
    logic [15:0] pop_q  [4] = '{16'd3, 16'd0, 16'd65535, 16'd77};
    logic [15:0] pop_r  [4] = '{16'd1, 16'd9, 16'd0, 16'd7};

    bit          pv [16];
    logic [31:0] pd [16];
    int          issued, max_fl, fl;
    bit          issue_now;

    initial begin
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_req_ready", 32'(o_req_ready), 32'd1);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_quotient", 32'(o_quotient), 32'd0);
        i_rstn = 1'b1;

        // Four issues fill the credit pool; a fifth request is ignored.
        tick();
        i_req_valid = 1'b1;
        repeat (4) @(posedge i_sclk);
        #1;
        @(negedge i_sclk);
        check("ready_low_after_4", 32'(o_req_ready), 32'd0);
        tick();
        i_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_div_valid     = 1'b1;
            i_div_quotient  = fill_q[k];
            i_div_remainder = fill_r[k];
            tick();
        end
        i_div_valid = 1'b0;
        @(negedge i_sclk);
        check("full_count", 32'(o_count), 32'd4);
        check("full_head_q", 32'(o_quotient), 32'd14);
        check("full_head_r", 32'(o_remainder), 32'd2);
        check("full_ready", 32'(o_req_ready), 32'd0);

        // Full with simultaneous push and pop.
        tick();
        i_ready = 1'b1;
        i_div_valid = 1'b1;
        i_div_quotient = 16'd77;
        i_div_remainder = 16'd7;
        tick();
        i_ready = 1'b0;
        i_div_valid = 1'b0;
        @(negedge i_sclk);
        check("pushpop_count", 32'(o_count), 32'd4);
        check("pushpop_ovf", 32'(o_overflow), 32'd0);
        check("pushpop_head_q", 32'(o_quotient), 32'd3);

        // Forced push into a full FIFO without pop is dropped.
        tick();
        i_div_valid = 1'b1;
        i_div_quotient = 16'd999;
        i_div_remainder = 16'd999;
        tick();
        i_div_valid = 1'b0;
        @(negedge i_sclk);
        check("ovf_set", 32'(o_overflow), 32'd1);
        check("ovf_count", 32'(o_count), 32'd4);
        tick();
        tick();
        @(negedge i_sclk);
        check("ovf_sticky", 32'(o_overflow), 32'd1);

        tick();
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_sclk);
            check("pop_q", 32'(o_quotient), 32'(pop_q[k]));
            check("pop_r", 32'(o_remainder), 32'(pop_r[k]));
            @(posedge i_sclk);
        end
        #1;
        i_ready = 1'b0;
        @(negedge i_sclk);
        check("drained_valid", 32'(o_valid), 32'd0);
        check("drained_quotient", 32'(o_quotient), 32'd0);
        check("drained_ovf", 32'(o_overflow), 32'd1);

        // Reset mid-operation with 3 queued and 1 in flight.
        tick();
        i_req_valid = 1'b1;
        repeat (4) @(posedge i_sclk);
        #1;
        i_req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_div_valid = 1'b1;
            i_div_quotient = 16'(10 + k);
            i_div_remainder = 16'(k);
            tick();
        end
        i_div_valid = 1'b0;
        #2;
        check("pre_rst_count", 32'(o_count), 32'd3);
        i_rstn = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_count", 32'(o_count), 32'd0);
        check("midrst_ready", 32'(o_req_ready), 32'd1);
        check("midrst_ovf", 32'(o_overflow), 32'd0);
        check("midrst_quotient", 32'(o_quotient), 32'd0);
        @(posedge i_sclk);
        #2;
        i_rstn = 1'b1;

        // Single result into an empty buffer with the consumer ready.
        tick();
        i_req_valid = 1'b1;
        tick();
        i_req_valid = 1'b0;
        i_ready = 1'b1;
        i_div_valid = 1'b1;
        i_div_quotient = 16'd100;
        i_div_remainder = 16'd5;
        @(negedge i_sclk);
`ifdef DIV_RESULT_BUF_BYPASS_EN
        check("byp_valid_now", 32'(o_valid), 32'd1);
        check("byp_q_now", 32'(o_quotient), 32'd100);
        check("byp_count_now", 32'(o_count), 32'd0);
`else
        check("nobyp_valid_now", 32'(o_valid), 32'd0);
        check("nobyp_count_now", 32'(o_count), 32'd0);
`endif
        tick();
        i_div_valid = 1'b0;
        @(negedge i_sclk);
`ifdef DIV_RESULT_BUF_BYPASS_EN
        check("byp_valid_next", 32'(o_valid), 32'd0);
        check("byp_count_next", 32'(o_count), 32'd0);
`else
        check("nobyp_valid_next", 32'(o_valid), 32'd1);
        check("nobyp_q_next", 32'(o_quotient), 32'd100);
        check("nobyp_r_next", 32'(o_remainder), 32'd5);
        check("nobyp_count_next", 32'(o_count), 32'd1);
`endif
        tick();
        @(negedge i_sclk);
        check("single_done_count", 32'(o_count), 32'd0);
        check("single_done_valid", 32'(o_valid), 32'd0);

        // Continuous issue through a 16-cycle divider pipeline.
        tick();
        pops_seen = 0;
        issued = 0;
        max_fl = 0;
        max_model_inflight = 0;
        for (int j = 0; j < 16; j++) begin
            pv[j] = 1'b0;
            pd[j] = '0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            fl = 0;
            for (int j = 0; j < 16; j++) fl += int'(pv[j]);
            if (fl > max_fl) max_fl = fl;
            i_req_valid = (cyc < 250);
            issue_now = (cyc < 250) && o_req_ready;
            i_div_valid = pv[15];
            {i_div_quotient, i_div_remainder} = pd[15];
            for (int j = 15; j > 0; j--) begin
                pv[j] = pv[j-1];
                pd[j] = pd[j-1];
            end
            pv[0] = issue_now;
            pd[0] = {16'(1000 + issued), 16'(issued)};
            if (issue_now) issued++;
            tick();
        end
        i_req_valid = 1'b0;
        i_div_valid = 1'b0;
        i_ready = 1'b0;
        @(negedge i_sclk);
        check("stream_all_delivered", 32'(pops_seen), 32'(issued));
        check("stream_pipe_inflight_ok", 32'(max_fl <= DEPTH), 32'd1);
        check("stream_model_inflight_ok", 32'(max_model_inflight <= DEPTH), 32'd1);
        check("stream_throughput", 32'(issued >= 40), 32'd1);
        check("stream_ovf", 32'(o_overflow), 32'd0);
        check("stream_count", 32'(o_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
